wav_record_buffer: RTL and testbench
====================================

// Module: wav_record_buffer
// PURPOSE
//  Sample store between the WM8731 codec interface (mywav) and the user controls.
//  Captures 16-bit record samples (wav_in_data/wav_wren) into on-chip RAM.
//  Replays them by serving wav_out_data on each wav_rden.
//  Record -> play loop-back without external memory; one clock domain (clk50M).
// PARAMETERS
//  AW      11          RAM address width; capacity DEPTH = 2**AW samples
//  DW      16          sample width, matches codec interface
// PORTS
//  clk50M        in   1      system clock, 50 MHz
//  rst           in   1      synchronous, active-high reset
//  record_en     in   1      level; rising edge starts a new recording at addr 0
//  play_en       in   1      level; rising edge starts playback at addr 0
//  wav_in_data   in   DW     record sample from codec ADC path
//  wav_wren      in   1      1-cycle strobe: wav_in_data valid
//  wav_rden      in   1      1-cycle strobe: codec DAC path consumed wav_out_data
//  wav_out_data  out  DW     current playback sample (registered)
//  rec_len       out  AW+1   samples held by last recording (0..DEPTH)
//  busy_rec      out  1      high in REC
//  busy_play     out  1      high in PLAY_FETCH/PLAY_WAIT
//  rec_full      out  1      sticky: recording stopped at DEPTH; cleared on next record start
//  play_done     out  1      high in PLAY_END
//  rden_miss     out  1      sticky: wav_rden arrived while fetch pending; cleared on play start
// BEHAVIOUR
//  Reset: state IDLE, all addrs 0, rec_len 0, wav_out_data 0, all flags 0.
//  Edge detect: record_en/play_en registered once; start = level & ~prev.
//  FSM: IDLE, REC, PLAY_FETCH, PLAY_WAIT, PLAY_END.
//   IDLE/PLAY_*: record start -> REC, wr_addr=0, rec_full=0. Record start has priority.
//   REC: wav_wren writes RAM[wr_addr], wr_addr++, rec_len=wr_addr+1 same cycle.
//    rec_len reaching DEPTH sets rec_full; later wren ignored.
//    record_en low -> IDLE; rec_len is kept.
//   IDLE/PLAY_END: play start with rec_len!=0 -> PLAY_FETCH, rd_addr=0.
//    rec_len==0 -> PLAY_END directly.
//   PLAY_FETCH: RAM read latency 1. wav_out_data loads RAM[rd_addr] 2 cycles after entry.
//    Then -> PLAY_WAIT.
//   PLAY_WAIT: wav_rden -> rd_addr++; rd_addr+1==rec_len -> end-of-data handling, else PLAY_FETCH.
//   PLAY_END: wav_out_data forced 0 (silence).
//   play_en low in any PLAY_* state -> IDLE, wav_out_data 0.
//  wav_rden outside PLAY_WAIT: ignored. In PLAY_FETCH it also sets rden_miss.
//  wav_wren outside REC: ignored. wren and rden same cycle: both honoured (separate RAM ports).
//  Codec strobes are >=1000 cycles apart at 48 kHz; 2-cycle fetch never limits rate.
//  Reset mid-operation: immediate return to reset values; RAM contents undefined/unused.
// CONFIGURATION
//  WAV_LOOP_PLAY_EN defined: end-of-data wraps rd_addr to 0 -> PLAY_FETCH; plays until play_en low.
//  Not defined: end-of-data -> PLAY_END; play_done held until next start or play_en low.
// STRUCTURE
//  wav_buf_pkg: state enum (5 codes), DW default, localparam DEPTH = 1<<AW.
//  Sub-module wav_buf_ram: simple dual-port RAM, DW x DEPTH.
//   Sync write port, registered read port, 1-cycle latency, no reset on array.
// TESTING
//  1 Reset, then idle 100 cycles -> all outputs 0, state IDLE.
//  2 Record 5 samples 0x1111..0x5555, drop record_en, then play.
//    -> wav_out_data 0x1111, each rden steps to next; after 5th rden play_done=1, out=0.
//  3 AW=3: record 10 samples -> rec_full=1 after 8th, rec_len=8, samples 9-10 not stored.
//  4 wav_rden 1 cycle after entering PLAY_FETCH -> rden_miss=1, rd_addr unchanged.
//  5 record_en and play_en rise same cycle -> REC entered, busy_play=0.
//  6 WAV_LOOP_PLAY_EN, rec_len=3 -> out sequence s0,s1,s2,s0,s1; play_done stays 0.

Source files
------------

// File: rtl/wav_buf_pkg.sv
// Shared types and defaults for the WAV record/playback buffer.
// The optional loop-playback feature is selected with the WAV_LOOP_PLAY_EN macro.
package wav_buf_pkg;

    localparam int AW_DEF = 11;
    localparam int DW_DEF = 16;
    localparam int DEPTH  = 1 << AW_DEF;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_REC        = 3'd1,
        ST_PLAY_FETCH = 3'd2,
        ST_PLAY_WAIT  = 3'd3,
        ST_PLAY_END   = 3'd4
    } wav_state_e;

endpackage

// File: rtl/wav_buf_ram.sv
// Simple dual-port sample RAM: synchronous write, registered read (1-cycle latency).
// The array is not reset; contents are only read back after being written.
module wav_buf_ram #(
    parameter int AW = 11,
    parameter int DW = 16
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;

    // Write port and registered read port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wav_record_buffer.sv
// Record/playback sample store between the codec interface and user controls.
// Define WAV_LOOP_PLAY_EN to make playback wrap to the first sample instead of stopping.
module wav_record_buffer
    import wav_buf_pkg::*;
#(
    parameter int AW = 11,
    parameter int DW = DW_DEF
) (
    input  logic          clk50M,
    input  logic          rst,
    input  logic          record_en,
    input  logic          play_en,
    input  logic [DW-1:0] wav_in_data,
    input  logic          wav_wren,
    input  logic          wav_rden,
    output logic [DW-1:0] wav_out_data,
    output logic [AW:0]   rec_len,
    output logic          busy_rec,
    output logic          busy_play,
    output logic          rec_full,
    output logic          play_done,
    output logic          rden_miss
);

    localparam logic [AW:0] ONE      = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] DEPTH_LV = {1'b1, {AW{1'b0}}};

    wav_state_e    state_q, state_d;
    logic [AW:0]   wr_addr_q, wr_addr_d;
    logic [AW:0]   rd_addr_q, rd_addr_d;
    logic [AW:0]   rec_len_q, rec_len_d;
    logic          rec_full_q, rec_full_d;
    logic          miss_q, miss_d;
    logic          fetch_q, fetch_d;
    logic [DW-1:0] out_q, out_d;
    logic          rec_prev_q, play_prev_q;
    logic          rec_start_s, play_start_s, ram_we_s;
    logic [DW-1:0] ram_rdata_s;

    assign rec_start_s  = record_en & ~rec_prev_q;
    assign play_start_s = play_en & ~play_prev_q;

    wav_buf_ram #(.AW(AW), .DW(DW)) u_ram (
        .clk_i   (clk50M),
        .we_i    (ram_we_s),
        .waddr_i (wr_addr_q[AW-1:0]),
        .wdata_i (wav_in_data),
        .raddr_i (rd_addr_q[AW-1:0]),
        .rdata_o (ram_rdata_s)
    );

    // State and datapath registers.
    always_ff @(posedge clk50M) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            rec_len_q   <= '0;
            rec_full_q  <= 1'b0;
            miss_q      <= 1'b0;
            fetch_q     <= 1'b0;
            out_q       <= '0;
            rec_prev_q  <= 1'b0;
            play_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            rec_len_q   <= rec_len_d;
            rec_full_q  <= rec_full_d;
            miss_q      <= miss_d;
            fetch_q     <= fetch_d;
            out_q       <= out_d;
            rec_prev_q  <= record_en;
            play_prev_q <= play_en;
        end
    end

    // Next-state logic; a record start overrides everything else.
    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        rec_len_d  = rec_len_q;
        rec_full_d = rec_full_q;
        miss_d     = miss_q;
        fetch_d    = 1'b0;
        out_d      = out_q;
        ram_we_s   = 1'b0;
        if (rec_start_s) begin
            state_d    = ST_REC;
            wr_addr_d  = '0;
            rec_len_d  = '0;
            rec_full_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_PLAY_END: begin
                    if (play_start_s) begin
                        miss_d = 1'b0;
                        if (rec_len_q != '0) begin
                            state_d   = ST_PLAY_FETCH;
                            rd_addr_d = '0;
                        end else begin
                            state_d = ST_PLAY_END;
                        end
                    end else if (!play_en) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_REC: begin
                    if (wav_wren && !rec_full_q) begin
                        ram_we_s   = 1'b1;
                        wr_addr_d  = wr_addr_q + ONE;
                        rec_len_d  = wr_addr_q + ONE;
                        rec_full_d = ((wr_addr_q + ONE) == DEPTH_LV);
                    end else begin
                        ram_we_s = 1'b0;
                    end
                    if (!record_en) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_REC;
                    end
                end
                ST_PLAY_FETCH: begin
                    if (!play_en) begin
                        state_d = ST_IDLE;
                    end else begin
                        if (wav_rden) begin
                            miss_d = 1'b1;
                        end else begin
                            miss_d = miss_q;
                        end
                        // Second cycle in fetch: registered RAM data is now valid.
                        if (fetch_q) begin
                            state_d = ST_PLAY_WAIT;
                            out_d   = ram_rdata_s;
                        end else begin
                            fetch_d = 1'b1;
                        end
                    end
                end
                ST_PLAY_WAIT: begin
                    if (!play_en) begin
                        state_d = ST_IDLE;
                    end else if (wav_rden) begin
                        if ((rd_addr_q + ONE) == rec_len_q) begin
`ifdef WAV_LOOP_PLAY_EN
                            rd_addr_d = '0;
                            state_d   = ST_PLAY_FETCH;
`else
                            rd_addr_d = rd_addr_q + ONE;
                            state_d   = ST_PLAY_END;
`endif
                        end else begin
                            rd_addr_d = rd_addr_q + ONE;
                            state_d   = ST_PLAY_FETCH;
                        end
                    end else begin
                        state_d = ST_PLAY_WAIT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        // Outside active playback the DAC path hears silence.
        if (state_d != ST_PLAY_FETCH && state_d != ST_PLAY_WAIT) begin
            out_d = '0;
        end else begin
            out_d = out_d;
        end
    end

    assign wav_out_data = out_q;
    assign rec_len      = rec_len_q;
    assign rec_full     = rec_full_q;
    assign rden_miss    = miss_q;
    assign busy_rec     = (state_q == ST_REC);
    assign busy_play    = (state_q == ST_PLAY_FETCH) || (state_q == ST_PLAY_WAIT);
    assign play_done    = (state_q == ST_PLAY_END);

endmodule

// File: tb/tb_wav_record_buffer.sv
// Directed bench for wav_record_buffer (AW=3) with a sample scoreboard.
// Loop-playback expectations follow WAV_LOOP_PLAY_EN.
module tb_wav_record_buffer;

    localparam int AW    = 3;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          record_en, play_en, wav_wren, wav_rden;
    logic [DW-1:0] wav_in_data;
    logic [DW-1:0] wav_out_data;
    logic [AW:0]   rec_len;
    logic          busy_rec, busy_play, rec_full, play_done, rden_miss;

    logic [DW-1:0] mdl_mem [DEPTH];
    int            mdl_len;
    logic [DW-1:0] exp_q [$];
    int            n_total = 0;
    int            n_fail  = 0;

    always #10 clk = ~clk;

    wav_record_buffer #(.AW(AW), .DW(DW)) dut (
        .clk50M       (clk),
        .rst          (rst),
        .record_en    (record_en),
        .play_en      (play_en),
        .wav_in_data  (wav_in_data),
        .wav_wren     (wav_wren),
        .wav_rden     (wav_rden),
        .wav_out_data (wav_out_data),
        .rec_len      (rec_len),
        .busy_rec     (busy_rec),
        .busy_play    (busy_play),
        .rec_full     (rec_full),
        .play_done    (play_done),
        .rden_miss    (rden_miss)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic record(input int n, input logic [DW-1:0] step, input logic with_play);
        logic [DW-1:0] v;
        record_en = 1'b1;
        play_en   = with_play;
        tick();
        chk("rec_busy", busy_rec, 1);
        chk("rec_no_play", busy_play, 0);
        mdl_len = 0;
        for (int i = 0; i < n; i++) begin
            v = DW'(step * (i + 1));
            wav_in_data = v;
            wav_wren    = 1'b1;
            tick();
            wav_wren = 1'b0;
            if (mdl_len < DEPTH) begin
                mdl_mem[mdl_len] = v;
                mdl_len++;
            end
            chk("rec_len_step", rec_len, mdl_len);
            chk("rec_full_step", rec_full, (mdl_len == DEPTH) ? 1 : 0);
            tick();
        end
        record_en = 1'b0;
        tick();
        chk("rec_idle", busy_rec, 0);
        chk("rec_idle_play", busy_play, 0);
        chk("rec_len_kept", rec_len, mdl_len);
        play_en = 1'b0;
        tick();
    endtask

    // Plays nsteps samples; expected sample sequence pushed from the model memory.
    task automatic play(input int nsteps, input logic exp_done);
        logic [DW-1:0] e;
        for (int k = 0; k < nsteps; k++) exp_q.push_back(mdl_mem[k % mdl_len]);
        play_en = 1'b1;
        tick(); tick(); tick();
        for (int k = 0; k < nsteps; k++) begin
            e = exp_q.pop_front();
            chk("play_sample", wav_out_data, e);
            chk("play_busy", busy_play, 1);
            wav_rden = 1'b1;
            tick();
            wav_rden = 1'b0;
            tick(); tick(); tick();
        end
        chk("play_done", play_done, exp_done);
        if (exp_done) begin
            chk("end_silence", wav_out_data, 0);
            chk("end_not_busy", busy_play, 0);
        end else begin
            chk("loop_busy", busy_play, 1);
        end
        play_en = 1'b0;
        tick();
        chk("stop_idle", busy_play, 0);
        chk("stop_done_clr", play_done, 0);
        chk("stop_silence", wav_out_data, 0);
    endtask

    initial begin
        rst = 1'b1; record_en = 1'b0; play_en = 1'b0;
        wav_in_data = '0; wav_wren = 1'b0; wav_rden = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        chk("rst_out", wav_out_data, 0);
        chk("rst_len", rec_len, 0);
        chk("rst_busy_rec", busy_rec, 0);
        chk("rst_busy_play", busy_play, 0);
        chk("rst_full", rec_full, 0);
        chk("rst_done", play_done, 0);
        chk("rst_miss", rden_miss, 0);

        // Play with nothing recorded goes straight to the end state.
        play_en = 1'b1;
        tick();
        chk("empty_done", play_done, 1);
        chk("empty_busy", busy_play, 0);
        play_en = 1'b0;
        tick();
        chk("empty_idle", play_done, 0);

        // Five samples, played back in order, ending in silence.
        record(5, 16'h1111, 1'b0);
        play(5, 1'b1);

        // Early rden during fetch: flagged, address not advanced.
        play_en = 1'b1;
        tick();
        wav_rden = 1'b1;
        tick();
        wav_rden = 1'b0;
        tick();
        chk("miss_set", rden_miss, 1);
        chk("miss_sample0", wav_out_data, mdl_mem[0]);
        wav_rden = 1'b1;
        tick();
        wav_rden = 1'b0;
        tick(); tick(); tick();
        chk("miss_sample1", wav_out_data, mdl_mem[1]);
        play_en = 1'b0;
        tick();
        chk("miss_stop", busy_play, 0);
        play_en = 1'b1;
        tick();
        chk("miss_clr", rden_miss, 0);
        play_en = 1'b0;
        tick();

        // Overfill: only DEPTH samples kept.
        record(10, 16'h0101, 1'b0);
        chk("full_len", rec_len, DEPTH);
        chk("full_flag", rec_full, 1);
        play(DEPTH, 1'b1);

        // Simultaneous record/play rise: record wins; full flag cleared.
        record(3, 16'h2345, 1'b1);
        chk("both_full_clr", rec_full, 0);
`ifdef WAV_LOOP_PLAY_EN
        play(5, 1'b0);
`else
        play(3, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
